// File: rtl/sort_pkg.sv
// sort_pkg: shared constants and types for the sort pipeline and its unloader.
//   M          : sort_top input vector length
//   N          : element width in bits
//   W          : number of sort stages == results per sort job
//   UNL_DEPTH  : unloader result-buffer depth in jobs (>=2)
//   res_vec_t  : one job's aligned result vector, lane 0 in the low bits
package sort_pkg;
  localparam int M         = 4;
  localparam int N         = 8;
  localparam int W         = 4;
  localparam int UNL_DEPTH = 4;

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam int CNT_W = $clog2(UNL_DEPTH + 1);
  localparam int PTR_W = $clog2(UNL_DEPTH);

  typedef logic [W-1:0][N-1:0] res_vec_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} unl_state_e;

  // Number of set bits in a tag vector (jobs still travelling through deskew).
  function automatic int popcnt(input logic [W-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) c += int'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/sort_unl_fifo.sv
// sort_unl_fifo: job-granular result FIFO for sort_unloader.
//   clk, rst_n : clock, async active-low reset
//   i_push     : write i_data at end of cycle (ignored when full unless popping)
//   i_data     : aligned result vector
//   i_pop      : drop head entry at end of cycle (ignored when empty)
//   o_head     : head entry (valid while o_empty=0)
//   o_empty    : registered empty flag
//   o_count    : registered occupancy
module sort_unl_fifo
  import sort_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  res_vec_t         i_data,
  input  logic             i_pop,
  output res_vec_t         o_head,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);
  res_vec_t         mem_q [UNL_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = i_pop & ~empty_q;
  assign do_push = i_push & (~full_q | do_pop);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(UNL_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(UNL_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_empty = empty_q;
  assign o_count = count_q;
endmodule

// File: rtl/sort_unloader.sv
// sort_unloader: deskews sort_top's staggered result lanes, buffers whole
// jobs, and serializes them one word per handshake in lane order.
//   clk, rst_n    : clock, async active-low reset
//   i_start       : job launch request (same cycle sort_top samples i_chi)
//   o_start_ready : a launch is accepted this cycle
//   i_y_q         : sort_top result lanes, lane i valid i+1 cycles after launch
//   o_valid/i_ready/o_data/o_idx/o_last : serialized output stream
//   o_drop        : pulse, cycle after an i_start that was refused
module sort_unloader
  import sort_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  output logic             o_start_ready,
  input  res_vec_t         i_y_q,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [N-1:0]     o_data,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last,
  output logic             o_drop
);
  logic             accept;
  logic [W-1:0]     tag_q, tag_d;
  logic             drop_q, drop_d;
  unl_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  res_vec_t         aligned, fifo_head;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             push, pop, hs, last;
  logic [CNT_W:0]   occ;

  // Credit covers both buffered jobs and jobs still in the deskew pipe, so an
  // accepted job always finds a FIFO slot when its tag exits.
  assign occ           = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(popcnt(tag_q));
  assign o_start_ready = (occ < (CNT_W+1)'(UNL_DEPTH));
  assign accept        = i_start & o_start_ready;

  // Tag bit j set means a job launched j+1 cycles ago; exit aligns with lanes.
  always_comb begin
    tag_d[0] = accept;
    for (int j = 1; j < W; j++) tag_d[j] = tag_q[j-1];
  end
  assign push = tag_q[W-1];

  // Lane i arrives i+1 cycles after launch; delay it W-1-i cycles so every
  // lane lines up with the undelayed top lane.
  for (genvar gi = 0; gi < W; gi++) begin : g_lane
    if (gi == W - 1) begin : g_thru
      assign aligned[gi] = i_y_q[gi];
    end else begin : g_dly
      localparam int D = W - 1 - gi;
      logic [D-1:0][N-1:0] sr_q, sr_d;
      always_comb begin
        sr_d[0] = i_y_q[gi];
        for (int j = 1; j < D; j++) sr_d[j] = sr_q[j-1];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
      end
      assign aligned[gi] = sr_q[D-1];
    end
  end

  sort_unl_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (push),
    .i_data  (aligned),
    .i_pop   (pop),
    .o_head  (fifo_head),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign o_valid = (state_q == ST_SEND);
  assign last    = o_valid && (idx_q == IDX_W'(W - 1));
  assign hs      = o_valid & i_ready;
  assign pop     = hs & last;

  // Entering SEND on the push edge makes the word visible as soon as the
  // FIFO entry is, giving W+1 cycles from launch to first o_valid.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drop_d  = i_start & ~o_start_ready;
    unique case (state_q)
      ST_IDLE: if (push || !fifo_empty) state_d = ST_SEND;
      ST_SEND: if (pop && !push && fifo_count == CNT_W'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (hs) idx_d = last ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      drop_q  <= 1'b0;
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      tag_q   <= tag_d;
      drop_q  <= drop_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign o_data = o_valid ? fifo_head[idx_q] : '0;
  assign o_idx  = idx_q;
  assign o_last = last;
  assign o_drop = drop_q;
endmodule

// File: tb/tb_sort_unloader.sv
// Randomized + directed bench for sort_unloader with a job-level reference model.
module tb_sort_unloader;
  import sort_pkg::*;

  localparam int MAXC = 4096;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic             o_start_ready;
  res_vec_t         i_y_q = '0;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic [N-1:0]     o_data;
  logic [IDX_W-1:0] o_idx;
  logic             o_last;
  logic             o_drop;

  sort_unloader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .o_start_ready (o_start_ready),
    .i_y_q         (i_y_q),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_data        (o_data),
    .o_idx         (o_idx),
    .o_last        (o_last),
    .o_drop        (o_drop)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: per-cycle lane stimulus schedule, queue of outstanding jobs with
  // the cycle each becomes visible, and job-level credit accounting.
  res_vec_t     sched   [MAXC];
  bit [W-1:0]   sched_v [MAXC];
  res_vec_t     jobq[$];
  int           availq[$];
  int           widx = 0;
  int           accepted = 0;
  int           completed = 0;
  bit           drop_pend = 0;
  res_vec_t     next_job;

  bit           obs_v  [MAXC];
  bit [N-1:0]   obs_d  [MAXC];
  bit           obs_l  [MAXC];
  bit           obs_r  [MAXC];
  bit           obs_dr [MAXC];
  bit           obs_hs [MAXC];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < MAXC; c++) sched_v[c] = '0;
    jobq.delete();
    availq.delete();
    widx = 0; accepted = 0; completed = 0; drop_pend = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs against model mid-cycle,
  // then advance the model to the end of the cycle.
  task automatic step(input bit st, input bit rdy);
    bit e_rdy, e_v;
    res_vec_t hj;
    @(posedge clk); #1;
    i_start = st;
    i_ready = rdy;
    for (int i = 0; i < W; i++)
      i_y_q[i] = sched_v[cyc][i] ? sched[cyc][i] : N'($urandom);
    @(negedge clk);
    e_rdy = (accepted - completed) < UNL_DEPTH;
    e_v   = (jobq.size() > 0) && (availq[0] <= cyc);
    chk("start_ready", int'(o_start_ready), int'(e_rdy));
    chk("drop", int'(o_drop), int'(drop_pend));
    chk("valid", int'(o_valid), int'(e_v));
    if (e_v) begin
      hj = jobq[0];
      chk("data", int'(o_data), int'(hj[widx]));
      chk("idx", int'(o_idx), widx);
      chk("last", int'(o_last), int'(widx == W - 1));
    end else begin
      chk("idle_data", int'(o_data), 0);
      chk("idle_last", int'(o_last), 0);
    end
    obs_v[cyc]  = o_valid;
    obs_d[cyc]  = o_data;
    obs_l[cyc]  = o_last;
    obs_r[cyc]  = o_start_ready;
    obs_dr[cyc] = o_drop;
    obs_hs[cyc] = o_valid & rdy;

    drop_pend = st && !e_rdy;
    if (e_v && rdy) begin
      if (widx == W - 1) begin
        widx = 0;
        void'(jobq.pop_front());
        void'(availq.pop_front());
        completed++;
      end else begin
        widx++;
      end
    end
    if (st && e_rdy) begin
      accepted++;
      for (int i = 0; i < W; i++) begin
        sched[cyc+1+i][i]   = next_job[i];
        sched_v[cyc+1+i][i] = 1'b1;
      end
      jobq.push_back(next_job);
      availq.push_back(cyc + W + 1);
    end
    cyc++;
  endtask

  initial begin
    int s, cnt;
    int stall [3];
    model_clear();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_last", int'(o_last), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_drop", int'(o_drop), 0);
    chk("rst_idx", int'(o_idx), 0);
    #3 rst_n = 1'b1;

    // Single job: lanes 11,22,33,44, always ready
    s = cyc;
    next_job = {8'h44, 8'h33, 8'h22, 8'h11};
    step(1'b1, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1);
    chk("lit_ready_first", int'(obs_r[s]), 1);
    chk("lit_v_c4", int'(obs_v[s+4]), 0);
    chk("lit_v_c5", int'(obs_v[s+5]), 1);
    chk("lit_d_c5", int'(obs_d[s+5]), 'h11);
    chk("lit_d_c6", int'(obs_d[s+6]), 'h22);
    chk("lit_d_c7", int'(obs_d[s+7]), 'h33);
    chk("lit_d_c8", int'(obs_d[s+8]), 'h44);
    chk("lit_l_c7", int'(obs_l[s+7]), 0);
    chk("lit_l_c8", int'(obs_l[s+8]), 1);
    chk("lit_v_c9", int'(obs_v[s+9]), 0);

    // Backpressure on word 2 for three cycles
    s = cyc;
    next_job = {8'h44, 8'h33, 8'h22, 8'h11};
    step(1'b1, 1'b1);
    for (int g = 0; g < 20 && !(widx == 2 && obs_v[cyc-1]); g++) step(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      stall[k] = cyc;
      step(1'b0, 1'b0);
    end
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) chk("lit_stall_data", int'(obs_d[stall[k]]), 'h33);
    cnt = 0;
    for (int c = s; c < cyc; c++) cnt += int'(obs_l[c] & obs_hs[c]);
    chk("lit_bp_last_once", cnt, 1);

    // Four back-to-back starts with no drain, fifth refused
    s = cyc;
    for (int k = 0; k < 5; k++) begin
      next_job = res_vec_t'({$urandom, $urandom});
      step(1'b1, 1'b0);
    end
    step(1'b0, 1'b0);
    chk("lit_b2b_ready3", int'(obs_r[s+3]), 1);
    chk("lit_b2b_ready4", int'(obs_r[s+4]), 0);
    chk("lit_b2b_drop", int'(obs_dr[s+5]), 1);
    cnt = 0;
    s = cyc;
    for (int k = 0; k < 24; k++) step(1'b0, 1'b1);
    for (int c = s; c < cyc; c++) cnt += int'(obs_hs[c]);
    chk("lit_b2b_words", cnt, 16);

    // Saturated traffic: start every cycle, always ready
    for (int k = 0; k < 60; k++) begin
      next_job = res_vec_t'({$urandom, $urandom});
      step(1'b1, 1'b1);
    end

    // Reset mid-job at o_idx=2
    next_job = {8'haa, 8'hbb, 8'hcc, 8'hdd};
    for (int g = 0; g < 40 && jobq.size() > 0; g++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int g = 0; g < 20 && widx != 2; g++) step(1'b0, 1'b1);
    @(posedge clk); #2;
    i_start = 1'b0;
    chk("pre_rst_idx", int'(o_idx), 2);
    chk("pre_rst_valid", int'(o_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_data", int'(o_data), 0);
    chk("mid_rst_last", int'(o_last), 0);
    model_clear();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    s = cyc;
    next_job = {8'h04, 8'h03, 8'h02, 8'h01};
    step(1'b1, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1);
    chk("lit_post_rst_first", int'(obs_d[s+5]), 'h01);
    chk("lit_post_rst_v4", int'(obs_v[s+4]), 0);

    // Randomized phase
    for (int k = 0; k < 1500; k++) begin
      next_job = res_vec_t'({$urandom, $urandom});
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
    end

    // Drain
    for (int g = 0; g < 100 && jobq.size() > 0; g++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("drain_valid", int'(o_valid), 0);
    chk("drain_ready", int'(o_start_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
